// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared encodings and alignment check for data_mem_ctrl.
// Revision    : 1.0
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reserved size is folded into the alignment error.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            SZ_WORD: r = (lo != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-lane strobes/replication for stores, lane select and
//               sign/zero extension for loads.
// Revision    : 1.0
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'h00;
        w_half  = i_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'h0;
        case (i_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        case (i_size)
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << i_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_wstrb = i_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_wstrb = 4'b1111;
                o_rdata = i_rword;
            end
            default: o_wstrb = 4'b0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Word-organised data memory with valid/ready handshake,
//               programmable wait states and sized, error-checked accesses.
// Revision    : 1.0
// ============================================================================
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter int                LATENCY     = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ready
);

    localparam int                IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]        c_lat    = 4'(LATENCY);
    localparam logic [3:0]        c_lat_m1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [ADDR_W-3:0] c_depth  = (ADDR_W-2)'(DEPTH_WORDS);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_idle;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_unsigned;
    logic              w_write;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_commit;
    logic [3:0]        w_strb;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_resp_data;

    assign w_idle    = (r_state == ST_IDLE);
    assign req_ready = w_idle && !rst;
    assign mem_ready = req_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt >= c_lat_m1));

    // With zero wait states the response is formed on the accepting edge,
    // so the live request must be used instead of the captured copy.
    assign w_addr     = w_idle ? req_addr     : r_addr;
    assign w_size     = w_idle ? req_size     : r_size;
    assign w_unsigned = w_idle ? req_unsigned : r_unsigned;
    assign w_write    = w_idle ? req_write    : r_write;
    assign w_wdata    = w_idle ? req_wdata    : r_wdata;

    assign w_off = w_addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];
    assign w_err = (w_addr < BASE_ADDR) || (w_off[ADDR_W-1:2] >= c_depth) ||
                   align_err(w_size, w_off[1:0]);
    assign w_commit    = w_enter_resp && !rst && w_write && !w_err;
    assign w_resp_data = (w_err || w_write) ? 32'h0 : w_ld_data;

    mem_lane_align u_align (
        .i_lo       (w_off[1:0]),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_wdata    (w_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_wstrb    (w_strb),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_lane_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= w_enter_resp;
            resp_err   <= w_enter_resp && w_err;
            resp_rdata <= w_enter_resp ? w_resp_data : 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_write    <= req_write;
                        r_wdata    <= req_wdata;
                        r_cnt      <= 4'd0;
                        r_state    <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt >= c_lat_m1) begin
                        r_cnt   <= c_lat;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed bench for data_mem_ctrl at LATENCY=2 and LATENCY=0.
// Revision    : 1.0
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [1:0]  size = 2'b10;
    logic        uns = 1'b0;
    logic [31:0] wdata = 32'h0;

    logic        rdy_a, rv_a, err_a, mr_a;
    logic        rdy_b, rv_b, err_b, mr_b;
    logic [31:0] rd_a, rd_b;
    logic        ready, rvalid, rerr, mready;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ready  = sel ? rdy_b : rdy_a;
    assign rvalid = sel ? rv_b  : rv_a;
    assign rerr   = sel ? err_b : err_a;
    assign rdata  = sel ? rd_b  : rd_a;
    assign mready = sel ? mr_b  : mr_a;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(valid && !sel), .req_ready(rdy_a),
        .req_write(write), .req_addr(addr), .req_size(size), .req_unsigned(uns),
        .req_wdata(wdata), .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a),
        .mem_ready(mr_a)
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(0), .BASE_ADDR(32'h100)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(valid && sel), .req_ready(rdy_b),
        .req_write(write), .req_addr(addr), .req_size(size), .req_unsigned(uns),
        .req_wdata(wdata), .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b),
        .mem_ready(mr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] wd);
        int n;
        @(negedge clk);
        write = w; addr = a; size = sz; uns = u; wdata = wd; valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic tx(input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic u, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        issue(tag, w, a, sz, u, wd);
        lat = 1;
        while (!rvalid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rvalid) lat = 99;
        chk({tag, "_lat"},  32'(lat),  32'(exp_lat));
        chk({tag, "_err"},  32'(rerr), 32'(exp_err));
        chk({tag, "_data"}, rdata,     exp_rd);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_rvalid", 32'(rv_a), 32'd0);
        chk("rst_rdata", rd_a, 32'h0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(rdy_a), 32'd1);
        chk("post_rst_mready", 32'(mready), 32'd1);

        // LATENCY=2 instance, word/byte/half paths
        tx("st_w10",   1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 3);
        tx("ld_w10",   0, 32'h10, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0, 3);
        @(posedge clk);
        #1;
        chk("resp_drop_valid", 32'(rvalid), 32'd0);
        chk("resp_drop_data",  rdata,       32'h0);
        tx("st_b11",   1, 32'h11, 2'b00, 0, 32'hAABBCC80, 32'h0,        0, 3);
        tx("ld_b11s",  0, 32'h11, 2'b00, 0, 32'h0,        32'hFFFFFF80, 0, 3);
        tx("ld_b11u",  0, 32'h11, 2'b00, 1, 32'h0,        32'h00000080, 0, 3);
        tx("ld_w10b",  0, 32'h10, 2'b10, 0, 32'h0,        32'hDEAD80EF, 0, 3);
        tx("ld_h10u",  0, 32'h10, 2'b01, 1, 32'h0,        32'h000080EF, 0, 3);
        tx("ld_h12s",  0, 32'h12, 2'b01, 0, 32'h0,        32'hFFFFDEAD, 0, 3);

        // Misaligned, reserved, out of range
        tx("ld_h13",   0, 32'h13, 2'b01, 0, 32'h0,        32'h0,        1, 3);
        tx("ld_w12",   0, 32'h12, 2'b10, 0, 32'h0,        32'h0,        1, 3);
        tx("st_w12",   1, 32'h12, 2'b10, 0, 32'h55555555, 32'h0,        1, 3);
        tx("ld_rsvd",  0, 32'h10, 2'b11, 0, 32'h0,        32'h0,        1, 3);
        tx("ld_w10c",  0, 32'h10, 2'b10, 0, 32'h0,        32'hDEAD80EF, 0, 3);
        tx("st_wffc",  1, 32'hFFC, 2'b10, 0, 32'h12345678, 32'h0,       0, 3);
        tx("st_w1000", 1, 32'h1000, 2'b10, 0, 32'hFFFFFFFF, 32'h0,      1, 3);
        tx("ld_wffc",  0, 32'hFFC, 2'b10, 0, 32'h0,       32'h12345678, 0, 3);

        // Half store preserves other lanes
        tx("st_w14",   1, 32'h14, 2'b10, 0, 32'h11223344, 32'h0,        0, 3);
        tx("st_h16",   1, 32'h16, 2'b01, 0, 32'h9999CAFE, 32'h0,        0, 3);
        tx("ld_w14",   0, 32'h14, 2'b10, 0, 32'h0,        32'hCAFE3344, 0, 3);
        tx("ld_b17u",  0, 32'h17, 2'b00, 1, 32'h0,        32'h000000CA, 0, 3);
        tx("ld_b14s",  0, 32'h14, 2'b00, 0, 32'h0,        32'h00000044, 0, 3);

        // Reset while a store waits
        issue("rst_mid", 1, 32'h10, 2'b10, 0, 32'hBADBAD00);
        chk("rst_mid_busy", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_rv1", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_rv2", 32'(rvalid), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd1);
        tx("rst_mid_ld", 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD80EF, 0, 3);

        // LATENCY=0 instance with BASE_ADDR=0x100
        sel = 1'b1;
        tx("b_st_w120", 1, 32'h120, 2'b10, 0, 32'h0F0F0F0F, 32'h0,        0, 1);
        tx("b_ld_w120", 0, 32'h120, 2'b10, 0, 32'h0,        32'h0F0F0F0F, 0, 1);
        tx("b_ld_wfc",  0, 32'hFC,  2'b10, 0, 32'h0,        32'h0,        1, 1);
        tx("b_st_b10ff",1, 32'h10FF, 2'b00, 0, 32'h0000007F, 32'h0,       0, 1);
        tx("b_ld_b10ff",0, 32'h10FF, 2'b00, 0, 32'h0,       32'h0000007F, 0, 1);
        tx("b_ld_w1100",0, 32'h1100, 2'b10, 0, 32'h0,       32'h0,        1, 1);

        // Back-to-back throughput with valid held high
        @(negedge clk);
        for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
        write = 1'b0; addr = 32'h120; size = 2'b10; uns = 1'b0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tput_ready%0d", i), 32'(ready), 32'((i % 2) == 0));
            chk($sformatf("tput_rv%0d", i), 32'(rvalid), 32'((i % 2) == 1));
            if (i % 2 == 1) chk($sformatf("tput_data%0d", i), rdata, 32'h0F0F0F0F);
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
